inst_fetch_responder: RTL and testbench
=======================================

# inst_fetch_responder

Memory-side responder for the instruction fetch interface. It takes the fetch address `PC` driven by the IF stage and returns `MEM_inst`. It signals `delay_hard` while a fetch is outstanding and reports address faults on `IADEE`/`IADFE`. Behind it sits a one-entry fetch buffer and an SRAM-like instruction bus master (req/addr_ok/data_ok), so memory latency is hidden from IF.

## Interface
- `RESET_PC`, `32'hbfc0_0004`: first PC after reset; used only for test documentation, no RTL behaviour.
- `clk` in 1: clock, all state on posedge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `PC` in 32: virtual fetch address from IF, valid every cycle.
- `int` in 1: pipeline redirect/flush; invalidates buffer, discards in-flight data.
- `MEM_inst` out 32: fetched instruction; 0 on fault or stall.
- `delay_hard` out 1: 1 = `MEM_inst` not valid for current `PC`; IF must hold.
- `IADEE` out 1: address error, `PC[1:0]!=0`.
- `IADFE` out 1: fetch fault, `PC[31:30]!=2'b10` (outside kseg0/kseg1).
- `inst_req` out 1: bus request.
- `inst_addr` out 32: physical address = `{3'b000, PC[28:0]}`.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: read data valid this cycle.
- `inst_rdata` in 32: read data.
- `miss_cnt` out 32: count of bus reads issued (wraps).

## Operation
- Buffer: `buf_valid`, `buf_tag[31:0]` (virtual PC), `buf_data[31:0]`. Hit = `buf_valid & buf_tag==PC`.
- `err = IADEE|IADFE`, combinational from `PC`. If `err`: `delay_hard=0`, `MEM_inst=0`, no bus request. Faults take priority over hit/miss.
- If hit and no error: `delay_hard=0`, `MEM_inst=buf_data`.
- If miss and no error: `delay_hard=1`, `MEM_inst=0`.
- FSM states:
  - IDLE:
    - `inst_req = miss & !err & !int`.
    - On `inst_req & inst_addr_ok`: latch `pend_pc=PC`, `miss_cnt+1`, go to WAIT.
  - WAIT:
    - `inst_req=0`.
    - On `inst_data_ok`:
      - If `drop=0`: write buffer {`pend_pc`, `inst_rdata`, valid}.
      - If `drop=1`: discard the data and clear `drop`.
      - Go to IDLE.
- `int`:
  - Clears `buf_valid` that cycle.
  - In WAIT, sets `drop`.
  - In IDLE, suppresses `inst_req`.
  - `int` and `inst_data_ok` in the same cycle: the data is discarded.
- `PC` change while in WAIT: the fill still completes under `pend_pc`. The new PC misses and is requested from IDLE afterwards. At most one bus transaction is outstanding.
- `inst_addr` tracks `PC` combinationally while `inst_req=1`. `inst_req` must not deassert before `addr_ok` unless `PC` changes or `int` asserts.
- Reset values:
  - FSM=IDLE; `buf_valid=0`, `drop=0`, `miss_cnt=0`, `pend_pc=0`.
  - Hence `delay_hard=1` for any error-free `PC`; `IADEE`/`IADFE` follow `PC`.
- Reset asserted mid-transaction: the state is abandoned. The bus slave is reset with the same signal, so no drain is needed.

## Timing
- Hit: zero-latency combinational path from `PC` to `MEM_inst`/`delay_hard`.
- Miss, `addr_ok` in cycle N, `data_ok` in N+1: buffer written at the end of N+1, hit in N+2. That gives a minimum of 2 stall cycles.
- Each extra wait cycle on `addr_ok` or `data_ok` adds one stall cycle.
- `miss_cnt` increments on the `addr_ok` handshake edge.

## Structure
- Shared header `mips_defs.vh`:
  - FSM encodings `FETCH_IDLE`, `FETCH_WAIT`.
  - Segment constants `KSEG_MASK=32'h1fff_ffff`, `KSEG_TOP=2'b10`.
  - Reset vector.
- One sub-module, `fetch_line_buf`: tag/data/valid register with write port, invalidate, and combinational hit compare.
- FSM, fault decode and counter live in the top module.

## Test plan
- Reset release with `PC=32'hbfc0_0004`, bus `addr_ok` immediate, `data_ok` one cycle later with `rdata=32'h2408_0001` -> `delay_hard` high 2 cycles, then `MEM_inst=32'h2408_0001`, `inst_addr=32'h1fc0_0004`, `miss_cnt=1`.
- `PC` held on a hit for 5 cycles -> no `inst_req`, `delay_hard=0`, `miss_cnt` unchanged.
- `PC=32'hbfc0_0006` -> `IADEE=1`, `delay_hard=0`, `MEM_inst=0`, no request. `PC=32'h0040_0000` -> `IADFE=1`, same response.
- `int` pulse while in WAIT, `data_ok` 3 cycles later with `32'hdead_beef` -> buffer not written. Same `PC` then re-requested; `miss_cnt` increments by 2 total.
- `addr_ok` held low 4 cycles -> `inst_req` stays high with stable `inst_addr`, 4 extra stall cycles.
- `reset` low during WAIT -> `buf_valid=0`, FSM IDLE, `miss_cnt=0` immediately, without waiting for `clk`.

Source files
------------

// File: rtl/inst_fetch_responder_pkg.sv
// Shared fetch-side definitions: FSM encoding, segment decode constants, reset vector.
package inst_fetch_responder_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] KSEG_MASK = 32'h1fff_ffff;
  localparam logic [1:0]  KSEG_TOP  = 2'b10;
  localparam logic [31:0] RESET_PC  = 32'hbfc0_0004;

  // kseg0/kseg1 both map onto the low 512 MB of physical space.
  function automatic logic [31:0] virt_to_phys(input logic [31:0] va);
    return va & KSEG_MASK;
  endfunction

endpackage

// File: rtl/inst_fetch_responder_fetch_line_buf.sv
// One-entry fetch buffer: tag/data/valid with write port, invalidate and combinational hit.
module fetch_line_buf
  import inst_fetch_responder_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [31:0]       wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv,
  input  logic [31:0]       lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] rd_data
);

  logic              buf_valid;
  logic [31:0]       buf_tag;
  logic [DATA_W-1:0] buf_data;

  // Invalidate wins over a simultaneous write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (inv) begin
      buf_valid <= 1'b0;
    end else if (wr_en) begin
      buf_valid <= 1'b1;
      buf_tag   <= wr_tag;
      buf_data  <= wr_data;
    end
  end

  assign hit     = buf_valid && (buf_tag == lookup_tag);
  assign rd_data = buf_data;

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: fault decode, one-entry buffer, and single-outstanding bus FSM.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        intr,
  output logic [31:0] MEM_inst,
  output logic        delay_hard,
  output logic        IADEE,
  output logic        IADFE,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] miss_cnt
);

  fetch_state_t state;
  logic         drop;
  logic [31:0]  pend_pc;
  logic         hit;
  logic [31:0]  buf_rd;
  logic         err;
  logic         fill;

  assign IADEE = (PC[1:0] != 2'b00);
  assign IADFE = (PC[31:30] != KSEG_TOP);
  assign err   = IADEE | IADFE;

  assign delay_hard = !err && !hit;
  assign MEM_inst   = (!err && hit) ? buf_rd : 32'h0;
  assign inst_req   = (state == FETCH_IDLE) && !hit && !err && !intr;
  assign inst_addr  = virt_to_phys(PC);

  // A flush in the same cycle as returning data also discards that data.
  assign fill = (state == FETCH_WAIT) && inst_data_ok && !drop && !intr;

  fetch_line_buf #(.DATA_W(DATA_W)) u_line_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (fill),
    .wr_tag     (pend_pc),
    .wr_data    (inst_rdata),
    .inv        (intr),
    .lookup_tag (PC),
    .hit        (hit),
    .rd_data    (buf_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH_IDLE;
      drop     <= 1'b0;
      pend_pc  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (inst_req && inst_addr_ok) begin
            pend_pc  <= PC;
            miss_cnt <= miss_cnt + 32'd1;
            state    <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (inst_data_ok) begin
            drop  <= 1'b0;
            state <= FETCH_IDLE;
          end else if (intr) begin
            drop <= 1'b1;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder with hand-computed expectations.
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        intr;
  logic [31:0] MEM_inst;
  logic        delay_hard;
  logic        IADEE;
  logic        IADFE;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int stalls;

  always #5 clk = ~clk;

  inst_fetch_responder dut (
    .clk          (clk),
    .reset        (reset),
    .PC           (PC),
    .intr         (intr),
    .MEM_inst     (MEM_inst),
    .delay_hard   (delay_hard),
    .IADEE        (IADEE),
    .IADFE        (IADFE),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .miss_cnt     (miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks follow 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; PC = 32'hbfc0_0004; intr = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    #12;
    chk("rst_delay", {31'b0, delay_hard}, 32'd1);
    chk("rst_cnt", miss_cnt, 32'd0);
    chk("rst_inst", MEM_inst, 32'd0);
    reset = 1'b1;
    tick();

    // Cold miss on the reset vector
    inst_addr_ok = 1'b1; #1;
    chk("m0_req", {31'b0, inst_req}, 32'd1);
    chk("m0_addr", inst_addr, 32'h1fc0_0004);
    chk("m0_delay", {31'b0, delay_hard}, 32'd1);
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; #1;
    chk("m1_delay", {31'b0, delay_hard}, 32'd1);
    chk("m1_req", {31'b0, inst_req}, 32'd0);
    chk("m1_cnt", miss_cnt, 32'd1);
    tick();
    inst_data_ok = 1'b0; inst_rdata = '0; #1;
    chk("m2_delay", {31'b0, delay_hard}, 32'd0);
    chk("m2_inst", MEM_inst, 32'h2408_0001);

    // Held hit
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("hit_req", {31'b0, inst_req}, 32'd0);
      chk("hit_delay", {31'b0, delay_hard}, 32'd0);
    end
    chk("hit_cnt", miss_cnt, 32'd1);

    // Faults
    PC = 32'hbfc0_0006; #1;
    chk("ade_flag", {30'b0, IADEE, IADFE}, 32'b10);
    chk("ade_delay", {31'b0, delay_hard}, 32'd0);
    chk("ade_inst", MEM_inst, 32'd0);
    chk("ade_req", {31'b0, inst_req}, 32'd0);
    PC = 32'h0040_0000; #1;
    chk("adf_flag", {30'b0, IADEE, IADFE}, 32'b01);
    chk("adf_delay", {31'b0, delay_hard}, 32'd0);
    chk("adf_inst", MEM_inst, 32'd0);
    chk("adf_req", {31'b0, inst_req}, 32'd0);
    tick(); #1;
    chk("adf_cnt", miss_cnt, 32'd1);

    // Flush while waiting: returned data must be dropped
    PC = 32'hbfc0_0008; inst_addr_ok = 1'b1; #1;
    chk("fl_req", {31'b0, inst_req}, 32'd1);
    tick();
    inst_addr_ok = 1'b0; intr = 1'b1; #1;
    chk("fl_cnt", miss_cnt, 32'd2);
    tick();
    intr = 1'b0;
    tick(); #1;
    chk("fl_wait_req", {31'b0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
    tick();
    inst_data_ok = 1'b0; inst_rdata = '0; #1;
    chk("fl_nowrite", {31'b0, delay_hard}, 32'd1);
    chk("fl_inst", MEM_inst, 32'd0);
    chk("fl_rereq", {31'b0, inst_req}, 32'd1);
    chk("fl_readdr", inst_addr, 32'h1fc0_0008);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2409_0002; #1;
    chk("fl_cnt2", miss_cnt, 32'd3);
    tick();
    inst_data_ok = 1'b0; #1;
    chk("fl_hit", MEM_inst, 32'h2409_0002);

    // addr_ok held off for 4 cycles
    PC = 32'hbfc0_000c; stalls = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ao_req", {31'b0, inst_req}, 32'd1);
      chk("ao_addr", inst_addr, 32'h1fc0_000c);
      if (delay_hard) stalls++;
      tick();
    end
    inst_addr_ok = 1'b1; #1;
    if (delay_hard) stalls++;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c1d_8000; #1;
    if (delay_hard) stalls++;
    tick();
    inst_data_ok = 1'b0; #1;
    chk("ao_stalls", stalls, 32'd6);
    chk("ao_hit", MEM_inst, 32'h3c1d_8000);
    chk("ao_cnt", miss_cnt, 32'd4);

    // Flush coincident with data_ok: data discarded
    PC = 32'hbfc0_0010; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; intr = 1'b1; inst_rdata = 32'h1111_1111;
    tick();
    inst_data_ok = 1'b0; intr = 1'b0; #1;
    chk("co_nowrite", {31'b0, delay_hard}, 32'd1);
    chk("co_rereq", {31'b0, inst_req}, 32'd1);
    chk("co_cnt", miss_cnt, 32'd5);

    // Reset asserted mid-transaction
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; #2;
    reset = 1'b0; #1;
    chk("ra_cnt", miss_cnt, 32'd0);
    chk("ra_idle_req", {31'b0, inst_req}, 32'd1);
    PC = 32'hbfc0_000c; #1;
    chk("ra_bufinv", {31'b0, delay_hard}, 32'd1);
    chk("ra_inst", MEM_inst, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
